instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Producer side of the fetch/decode pipeline register: owns the PC and the instruction memory.
- Drives pc/instruction toward the IF/ID register, which samples on negedge clock_i under en_pipeline.
- Also owns the program loader: the debug unit streams bytes in, and they are packed into 32-bit words.
- Sequencing: load, run, stop on a halt word, report status back to the debug unit.

Parameters:
- NB_DATA, 32, instruction width; fixed at 32 (loader packs exactly 4 bytes).
- NB_PC, 7, PC / memory address width; memory depth = 2**NB_PC = 128 words.
- HALT_WORD, 32'hFFFF_FFFF, instruction value that marks end of program.

Ports:
- clock_i  in  1  system clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- en_pipeline  in  1  pipeline advance enable from debug unit; low freezes the PC in RUN.
- load_start_i  in  1  one-cycle pulse: begin loading a program.
- load_valid_i  in  1  load_byte_i valid this cycle.
- load_byte_i  in  8  program byte, most-significant byte of each word first.
- run_start_i  in  1  one-cycle pulse: start execution at PC 0.
- stall_i  in  1  hazard stall from hazard unit; holds the PC.
- pc_src_i  in  1  branch/jump taken; redirect the PC.
- pc_branch_i  in  NB_PC  redirect target (word address).
- pc_o  out  NB_PC  pc_reg+1, mod 2**NB_PC, toward IF/ID.
- instruction_o  out  NB_DATA  fetched instruction; 0 (NOP) outside RUN.
- halt_o  out  1  high while in HALTED.
- load_done_o  out  1  one-cycle pulse when HALT_WORD is written.
- load_error_o  out  1  sticky: memory filled without a HALT_WORD.
- loaded_o  out  1  a valid program is resident.
- state_o  out  2  IDLE=00, LOAD=01, RUN=10, HALTED=11.

Behaviour:
- Reset values:
  - state IDLE; pc_reg 0, so pc_o=1; wr_ptr 0; byte_cnt 0; word buffer 0.
  - halt_o, load_done_o, load_error_o and loaded_o are all 0.
  - Memory contents are not reset.
- Reset during any state aborts it: a partial word is discarded and loaded_o is cleared.
- Memory: synchronous write; asynchronous (combinational) read at pc_reg.
  - instruction_o = mem[pc_reg] when state==RUN, else 0.
  - Zero added latency, so IF/ID captures it on the following negedge.
- IDLE:
  - load_start_i -> LOAD; clears wr_ptr, byte_cnt, load_error_o and loaded_o.
  - run_start_i with loaded_o=1 -> RUN with pc_reg=0. run_start_i with loaded_o=0 is ignored.
  - load_start_i and run_start_i together: load wins.
- LOAD, each cycle with load_valid_i=1:
  - buffer <= {buffer[23:0], load_byte_i}; byte_cnt++.
  - On the 4th byte (byte_cnt==3): write the assembled word to mem[wr_ptr], wr_ptr++, byte_cnt=0.
  - Assembled word == HALT_WORD: the word is written, -> IDLE, loaded_o=1, load_done_o pulses for 1 cycle.
  - Word written at wr_ptr==2**NB_PC-1 and not HALT_WORD: -> IDLE, load_error_o=1, loaded_o=0. wr_ptr never wraps.
  - load_valid_i=0 holds all loader state; gaps of any length are legal.
  - load_start_i during LOAD restarts the load (wr_ptr and byte_cnt cleared).
  - run_start_i is ignored in LOAD.
- RUN, with en_pipeline=1, in priority order:
  1. pc_src_i=1: pc_reg <= pc_branch_i. This overrides a stall and a fetched HALT_WORD (wrong-path flush).
  2. mem[pc_reg]==HALT_WORD: pc_reg holds, -> HALTED.
  3. stall_i=1: pc_reg holds.
  4. Otherwise pc_reg <= pc_reg+1, wrapping mod 2**NB_PC.
- RUN, with en_pipeline=0: pc_reg and state frozen, all inputs ignored. This is step mode.
- HALTED:
  - halt_o=1; instruction_o=0; pc_reg holds the halt address.
  - load_start_i -> LOAD.
  - run_start_i -> RUN with pc_reg=0.
  - Both together: load wins.
- load_start_i or run_start_i asserted while in RUN: ignored.
- All outputs except instruction_o and pc_o are registered.

Test Plan:
1. Reset -> state_o=00, pc_o=1, instruction_o=0, loaded_o=0. Load bytes 20,08,00,05,FF,FF,FF,FF -> mem[0]=32'h2008_0005, mem[1]=HALT_WORD, load_done_o one pulse, loaded_o=1, state_o=00.
2. Load 3 words plus halt, then run_start_i with en_pipeline=1 -> instruction_o cycles through mem[0..2], pc_o goes 1,2,3. At PC 3: halt_o=1, state_o=11, instruction_o=0, pc_o stays 4.
3. In RUN at pc_reg=2: stall_i=1 for 2 cycles -> pc_o held at 3. Then stall_i=1 and pc_src_i=1 with pc_branch_i=0 together -> pc_reg=0 next cycle.
4. Branch to a HALT_WORD address with pc_src_i=1 in the same cycle the halt is fetched -> redirect taken, stays RUN. Toggle en_pipeline=0 for 3 cycles -> pc_reg frozen, state unchanged.
5. Stream 512 bytes with no HALT_WORD -> load_error_o=1, loaded_o=0, state_o=00. run_start_i is then ignored; a subsequent load_start_i clears load_error_o.
6. Assert reset_i after 2 bytes of a word -> state_o=00, loaded_o=0. A fresh load starts at mem[0] with byte_cnt=0. Insert gaps with load_valid_i=0 mid-word -> the word still assembles correctly.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - debug-unit side of the fetch unit: loader stream, run control, status
interface instruction_fetch_unit_if;
    logic       en_pipeline;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_byte;
    logic       run_start;
    logic       halt;
    logic       load_done;
    logic       load_error;
    logic       loaded;
    logic [1:0] state;

    // Debug unit drives control and program bytes, observes status
    modport master (
        output en_pipeline, load_start, load_valid, load_byte, run_start,
        input  halt, load_done, load_error, loaded, state
    );

    // Fetch unit consumes control and program bytes, reports status
    modport slave (
        input  en_pipeline, load_start, load_valid, load_byte, run_start,
        output halt, load_done, load_error, loaded, state
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, instruction memory, byte-stream program loader and run sequencing
module instruction_fetch_unit #(
    parameter int                NB_DATA   = 32,
    parameter int                NB_PC     = 7,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    instruction_fetch_unit_if.slave   dbg,
    input  logic                      stall_i,
    input  logic                      pc_src_i,
    input  logic [NB_PC-1:0]          pc_branch_i,
    output logic [NB_PC-1:0]          pc_o,
    output logic [NB_DATA-1:0]        instruction_o
);

    localparam int               DEPTH     = 2 ** NB_PC;
    localparam logic [NB_PC-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOAD   = 2'b01,
        S_RUN    = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    state_t             state_q;
    logic [NB_PC-1:0]   pc_q;
    logic [NB_PC-1:0]   wr_ptr_q;
    logic [1:0]         byte_cnt_q;
    logic [NB_DATA-1:0] buf_q;
    logic               halt_q;
    logic               load_done_q;
    logic               load_error_q;
    logic               loaded_q;

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [NB_DATA-1:0] assembled;
    logic [NB_DATA-1:0] fetched;
    logic               word_wr;

    // Word formed by shifting the incoming byte into the buffer (MSB first)
    assign assembled = {buf_q[NB_DATA-9:0], dbg.load_byte};
    assign fetched   = mem[pc_q];
    // A word is complete on the 4th accepted byte; a restart pulse discards it
    assign word_wr   = (state_q == S_LOAD) && dbg.load_valid && !dbg.load_start
                       && (byte_cnt_q == 2'd3) && !reset_i;

    assign pc_o          = pc_q + 1'b1;
    assign instruction_o = (state_q == S_RUN) ? fetched : '0;

    assign dbg.halt       = halt_q;
    assign dbg.load_done  = load_done_q;
    assign dbg.load_error = load_error_q;
    assign dbg.loaded     = loaded_q;
    assign dbg.state      = state_q;

    // Instruction memory write port; contents survive reset
    always_ff @(posedge clock_i) begin
        if (word_wr) begin
            mem[wr_ptr_q] <= assembled;
        end
    end

    // Sequencer: loader, PC update and registered status outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            wr_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            buf_q        <= '0;
            halt_q       <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dbg.load_start) begin
                        state_q      <= S_LOAD;
                        wr_ptr_q     <= '0;
                        byte_cnt_q   <= '0;
                        load_error_q <= 1'b0;
                        loaded_q     <= 1'b0;
                    end else if (dbg.run_start && loaded_q) begin
                        state_q <= S_RUN;
                        pc_q    <= '0;
                    end
                end
                S_LOAD: begin
                    if (dbg.load_start) begin
                        wr_ptr_q   <= '0;
                        byte_cnt_q <= '0;
                    end else if (dbg.load_valid) begin
                        buf_q <= assembled;
                        if (byte_cnt_q == 2'd3) begin
                            byte_cnt_q <= '0;
                            if (wr_ptr_q != LAST_ADDR) begin
                                wr_ptr_q <= wr_ptr_q + 1'b1;
                            end
                            if (assembled == HALT_WORD) begin
                                state_q     <= S_IDLE;
                                loaded_q    <= 1'b1;
                                load_done_q <= 1'b1;
                            end else if (wr_ptr_q == LAST_ADDR) begin
                                state_q      <= S_IDLE;
                                load_error_q <= 1'b1;
                                loaded_q     <= 1'b0;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // A taken branch flushes a wrong-path halt and overrides a stall
                    if (dbg.en_pipeline) begin
                        if (pc_src_i) begin
                            pc_q <= pc_branch_i;
                        end else if (fetched == HALT_WORD) begin
                            state_q <= S_HALTED;
                            halt_q  <= 1'b1;
                        end else if (!stall_i) begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end
                end
                S_HALTED: begin
                    if (dbg.load_start) begin
                        state_q      <= S_LOAD;
                        halt_q       <= 1'b0;
                        wr_ptr_q     <= '0;
                        byte_cnt_q   <= '0;
                        load_error_q <= 1'b0;
                        loaded_q     <= 1'b0;
                    end else if (dbg.run_start) begin
                        state_q <= S_RUN;
                        halt_q  <= 1'b0;
                        pc_q    <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset_i;
    logic        stall_i;
    logic        pc_src_i;
    logic [6:0]  pc_branch_i;
    logic [6:0]  pc_o;
    logic [31:0] instruction_o;

    instruction_fetch_unit_if dbg ();

    instruction_fetch_unit dut (
        .clock_i       (clk),
        .reset_i       (reset_i),
        .dbg           (dbg.slave),
        .stall_i       (stall_i),
        .pc_src_i      (pc_src_i),
        .pc_branch_i   (pc_branch_i),
        .pc_o          (pc_o),
        .instruction_o (instruction_o)
    );

    typedef struct {
        string       name;
        logic [6:0]  pc;
        logic [31:0] ins;
        logic [1:0]  st;
        logic [3:0]  fl;   // {halt, loaded, load_error, load_done}
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every queued expectation is compared against the DUT at the next falling edge
    always @(negedge clk) begin
        exp_t        e;
        logic [44:0] act;
        logic [44:0] req;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {pc_o, instruction_o, dbg.state, dbg.halt, dbg.loaded, dbg.load_error, dbg.load_done};
            req = {e.pc, e.ins, e.st, e.fl};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL %s: got pc=%h ins=%h st=%b fl=%b expected pc=%h ins=%h st=%b fl=%b",
                         e.name, act[44:38], act[37:6], act[5:4], act[3:0],
                         e.pc, e.ins, e.st, e.fl);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string n, input logic [6:0] pc, input logic [31:0] ins,
                              input logic [1:0] st, input logic [3:0] fl);
        exp_t e;
        e.name = n; e.pc = pc; e.ins = ins; e.st = st; e.fl = fl;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        dbg.load_valid = 1'b1;
        dbg.load_byte  = b;
        tick();
        dbg.load_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_load();
        dbg.load_start = 1'b1;
        tick();
        dbg.load_start = 1'b0;
    endtask

    task automatic pulse_run();
        dbg.run_start = 1'b1;
        tick();
        dbg.run_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i         = 1'b1;
        stall_i         = 1'b0;
        pc_src_i        = 1'b0;
        pc_branch_i     = '0;
        dbg.en_pipeline = 1'b1;
        dbg.load_start  = 1'b0;
        dbg.load_valid  = 1'b0;
        dbg.load_byte   = '0;
        dbg.run_start   = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;

        // 1. reset state and a two-word load
        expect_out("reset", 7'd1, 32'h0, 2'b00, 4'b0000);
        pulse_load();
        expect_out("t1_load_state", 7'd1, 32'h0, 2'b01, 4'b0000);
        send_word(32'h2008_0005);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        expect_out("t1_before_halt", 7'd1, 32'h0, 2'b01, 4'b0000);
        send_byte(8'hFF);
        expect_out("t1_load_done", 7'd1, 32'h0, 2'b00, 4'b0101);
        tick();
        expect_out("t1_done_pulse_end", 7'd1, 32'h0, 2'b00, 4'b0100);
        pulse_run();
        expect_out("t1_mem0", 7'd1, 32'h2008_0005, 2'b10, 4'b0100);
        tick();
        expect_out("t1_mem1", 7'd2, 32'hFFFF_FFFF, 2'b10, 4'b0100);
        tick();
        expect_out("t1_halted", 7'd2, 32'h0, 2'b11, 4'b1100);

        // 2. three words plus halt, run to halt
        pulse_load();
        expect_out("t2_load_from_halt", 7'd2, 32'h0, 2'b01, 4'b0000);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        send_word(32'hFFFF_FFFF);
        expect_out("t2_loaded", 7'd2, 32'h0, 2'b00, 4'b0101);
        pulse_run();
        expect_out("t2_pc0", 7'd1, 32'h1111_1111, 2'b10, 4'b0100);
        tick();
        expect_out("t2_pc1", 7'd2, 32'h2222_2222, 2'b10, 4'b0100);
        tick();
        expect_out("t2_pc2", 7'd3, 32'h3333_3333, 2'b10, 4'b0100);
        tick();
        expect_out("t2_pc3_haltword", 7'd4, 32'hFFFF_FFFF, 2'b10, 4'b0100);
        tick();
        expect_out("t2_halted", 7'd4, 32'h0, 2'b11, 4'b1100);
        tick();
        expect_out("t2_halt_hold", 7'd4, 32'h0, 2'b11, 4'b1100);

        // 3. stall holds PC; branch overrides stall
        pulse_run();
        expect_out("t3_rerun", 7'd1, 32'h1111_1111, 2'b10, 4'b0100);
        tick();
        tick();
        expect_out("t3_pc2", 7'd3, 32'h3333_3333, 2'b10, 4'b0100);
        stall_i = 1'b1;
        tick();
        expect_out("t3_stall1", 7'd3, 32'h3333_3333, 2'b10, 4'b0100);
        tick();
        expect_out("t3_stall2", 7'd3, 32'h3333_3333, 2'b10, 4'b0100);
        pc_src_i    = 1'b1;
        pc_branch_i = 7'd0;
        tick();
        expect_out("t3_branch_over_stall", 7'd1, 32'h1111_1111, 2'b10, 4'b0100);
        stall_i = 1'b0;

        // 4. branch onto halt word, redirect in the halt cycle, then step-mode freeze
        pc_branch_i = 7'd3;
        tick();
        expect_out("t4_at_haltword", 7'd4, 32'hFFFF_FFFF, 2'b10, 4'b0100);
        pc_branch_i = 7'd1;
        tick();
        expect_out("t4_flush_halt", 7'd2, 32'h2222_2222, 2'b10, 4'b0100);
        dbg.en_pipeline = 1'b0;
        pc_branch_i     = 7'd5;
        dbg.load_start  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("t4_frozen", 7'd2, 32'h2222_2222, 2'b10, 4'b0100);
        end
        dbg.load_start  = 1'b0;
        dbg.en_pipeline = 1'b1;
        pc_src_i        = 1'b0;
        tick();
        expect_out("t4_resume", 7'd3, 32'h3333_3333, 2'b10, 4'b0100);
        tick();
        tick();
        expect_out("t4_halted", 7'd4, 32'h0, 2'b11, 4'b1100);

        // 5. fill memory without a halt word
        pulse_load();
        for (int i = 0; i < 511; i++) begin
            send_byte(8'(i));
        end
        expect_out("t5_before_last", 7'd4, 32'h0, 2'b01, 4'b0000);
        send_byte(8'(511));
        expect_out("t5_overflow", 7'd4, 32'h0, 2'b00, 4'b0010);
        pulse_run();
        expect_out("t5_run_ignored", 7'd4, 32'h0, 2'b00, 4'b0010);
        pulse_load();
        expect_out("t5_error_cleared", 7'd4, 32'h0, 2'b01, 4'b0000);

        // 6. reset mid-word, then a load with gaps
        send_byte(8'h12);
        send_byte(8'h34);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        expect_out("t6_reset_abort", 7'd1, 32'h0, 2'b00, 4'b0000);
        pulse_load();
        send_byte(8'hA1);
        tick(); tick(); tick();
        expect_out("t6_gap", 7'd1, 32'h0, 2'b01, 4'b0000);
        send_byte(8'hB2);
        send_byte(8'hC3);
        tick(); tick();
        send_byte(8'hD4);
        send_word(32'hFFFF_FFFF);
        expect_out("t6_loaded", 7'd1, 32'h0, 2'b00, 4'b0101);
        pulse_run();
        expect_out("t6_word_gaps", 7'd1, 32'hA1B2_C3D4, 2'b10, 4'b0100);
        tick();
        expect_out("t6_haltword", 7'd2, 32'hFFFF_FFFF, 2'b10, 4'b0100);
        tick();
        expect_out("t6_halted", 7'd2, 32'h0, 2'b11, 4'b1100);
        dbg.load_start = 1'b1;
        dbg.run_start  = 1'b1;
        tick();
        dbg.load_start = 1'b0;
        dbg.run_start  = 1'b0;
        expect_out("t6_load_wins", 7'd2, 32'h0, 2'b01, 4'b0000);

        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            tick();
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
